// File: rtl/peak_search_sched.sv
// Run sequencer for the streaming peak detector: holdoff, then repeated search/guard
// windows counted in accepted sample beats, with beat-accurate peak timestamps.
module peak_search_sched #(
  parameter int CNT_WIDTH = 16,
  parameter int TS_WIDTH  = 32
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic [CNT_WIDTH-1:0] cfg_holdoff_i,
  input  logic [CNT_WIDTH-1:0] cfg_window_i,
  input  logic [CNT_WIDTH-1:0] cfg_guard_i,
  input  logic [7:0]           cfg_nsearch_i,
  input  logic                 s_beat_i,
  input  logic                 det_in_i,
  output logic                 arm_o,
  output logic                 busy_o,
  output logic                 pk_valid_o,
  output logic [TS_WIDTH-1:0]  pk_index_o,
  output logic [7:0]           pk_seq_o,
  output logic                 timeout_o,
  output logic                 done_o
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_HOLDOFF = 2'd1;
  localparam logic [1:0] S_SEARCH  = 2'd2;
  localparam logic [1:0] S_GUARD   = 2'd3;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [TS_WIDTH-1:0]  TS_ONE  = TS_WIDTH'(1);

  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] phase_q, phase_d;
  logic [TS_WIDTH-1:0]  ts_q, ts_d;
  logic [CNT_WIDTH-1:0] holdoff_q, holdoff_d;
  logic [CNT_WIDTH-1:0] window_q, window_d;
  logic [CNT_WIDTH-1:0] guard_q, guard_d;
  logic [7:0]           nsearch_q, nsearch_d;
  logic [7:0]           pk_seq_q, pk_seq_d;
  logic [TS_WIDTH-1:0]  pk_index_q, pk_index_d;
  logic                 pk_valid_q, pk_valid_d;
  logic                 timeout_q, timeout_d;
  logic                 done_q, done_d;
  logic                 arm_q, busy_q;
  logic [7:0]           seq_inc;

  always_comb begin
    state_d    = state_q;
    holdoff_d  = holdoff_q;
    window_d   = window_q;
    guard_d    = guard_q;
    nsearch_d  = nsearch_q;
    pk_seq_d   = pk_seq_q;
    pk_index_d = pk_index_q;
    pk_valid_d = 1'b0;
    timeout_d  = 1'b0;
    done_d     = 1'b0;
    seq_inc    = pk_seq_q + 8'd1;

    if (state_q == S_IDLE) begin
      // start wins over a simultaneous stop; stop alone is meaningless here
      if (start_i) begin
        state_d   = S_HOLDOFF;
        holdoff_d = cfg_holdoff_i;
        window_d  = cfg_window_i;
        guard_d   = cfg_guard_i;
        nsearch_d = cfg_nsearch_i;
        pk_seq_d  = 8'd0;
      end
    end else if (stop_i) begin
      state_d = S_IDLE;
      done_d  = 1'b1;
    end else begin
      case (state_q)
        S_HOLDOFF: begin
          if (phase_q == holdoff_q) state_d = S_SEARCH;
        end
        S_SEARCH: begin
          if (det_in_i) begin
            pk_valid_d = 1'b1;
            pk_index_d = ts_q;
            state_d    = S_GUARD;
          end else if (phase_q == window_q) begin
            timeout_d = 1'b1;
            state_d   = S_GUARD;
          end
        end
        S_GUARD: begin
          if (phase_q == guard_q) begin
            pk_seq_d = seq_inc;
            if (nsearch_q != 8'd0 && seq_inc == nsearch_q) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_SEARCH;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Every state change clears the phase count, so each phase counts from zero.
  always_comb begin
    phase_d = phase_q;
    if (state_d != state_q)                   phase_d = '0;
    else if (s_beat_i && (phase_q != '1))     phase_d = phase_q + CNT_ONE;
  end

  always_comb begin
    ts_d = ts_q;
    if (state_q == S_IDLE) begin
      if (start_i) ts_d = '0;
    end else if (s_beat_i) begin
      ts_d = ts_q + TS_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      state_q    <= S_IDLE;
      phase_q    <= '0;
      ts_q       <= '0;
      holdoff_q  <= '0;
      window_q   <= '0;
      guard_q    <= '0;
      nsearch_q  <= '0;
      pk_seq_q   <= '0;
      pk_index_q <= '0;
      pk_valid_q <= 1'b0;
      timeout_q  <= 1'b0;
      done_q     <= 1'b0;
      arm_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      ts_q       <= ts_d;
      holdoff_q  <= holdoff_d;
      window_q   <= window_d;
      guard_q    <= guard_d;
      nsearch_q  <= nsearch_d;
      pk_seq_q   <= pk_seq_d;
      pk_index_q <= pk_index_d;
      pk_valid_q <= pk_valid_d;
      timeout_q  <= timeout_d;
      done_q     <= done_d;
      arm_q      <= (state_d == S_SEARCH);
      busy_q     <= (state_d != S_IDLE);
    end
  end

  assign arm_o      = arm_q;
  assign busy_o     = busy_q;
  assign pk_valid_o = pk_valid_q;
  assign pk_index_o = pk_index_q;
  assign pk_seq_o   = pk_seq_q;
  assign timeout_o  = timeout_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_peak_search_sched.sv
// Bench for peak_search_sched: table of single-window runs plus hand-written
// stop/clear/continuous sequences; peak/timeout events checked against a queue.
module tb_peak_search_sched;
  localparam int CW = 16;
  localparam int TW = 32;

  logic          clk = 1'b0;
  logic          reset, clear, start, stop, s_beat, det_in;
  logic [CW-1:0] cfg_holdoff, cfg_window, cfg_guard;
  logic [7:0]    cfg_nsearch;
  logic          arm, busy, pk_valid, timeout, done;
  logic [TW-1:0] pk_index;
  logic [7:0]    pk_seq;

  int checks = 0;
  int errors = 0;
  int n_done = 0;
  int last_idx = 0;

  typedef struct { logic peak; logic [31:0] idx; logic [7:0] seq; } ev_t;
  ev_t sb[$];

  typedef struct { int h; int w; int g; bit gap; int det; bit peak; int idx; int armc; } vec_t;
  vec_t vt[7];

  always #5 clk = ~clk;

  peak_search_sched #(.CNT_WIDTH(CW), .TS_WIDTH(TW)) dut (
    .clk_i(clk), .reset_i(reset), .clear_i(clear), .start_i(start), .stop_i(stop),
    .cfg_holdoff_i(cfg_holdoff), .cfg_window_i(cfg_window), .cfg_guard_i(cfg_guard),
    .cfg_nsearch_i(cfg_nsearch), .s_beat_i(s_beat), .det_in_i(det_in),
    .arm_o(arm), .busy_o(busy), .pk_valid_o(pk_valid), .pk_index_o(pk_index),
    .pk_seq_o(pk_seq), .timeout_o(timeout), .done_o(done)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic sample();
    ev_t e;
    if (pk_valid || timeout) begin
      if (sb.size() == 0) begin
        chk("unexpected_event", {30'd0, pk_valid, timeout}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("event_kind", {31'd0, pk_valid}, {31'd0, e.peak});
        chk("event_excl", {31'd0, pk_valid & timeout}, 32'd0);
        if (e.peak) chk("pk_index", pk_index, e.idx);
        chk("pk_seq", {24'd0, pk_seq}, {24'd0, e.seq});
      end
    end
    if (done) n_done++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    sample();
  endtask

  task automatic set_cfg(input int h, input int w, input int g, input int ns);
    cfg_holdoff = CW'(h);
    cfg_window  = CW'(w);
    cfg_guard   = CW'(g);
    cfg_nsearch = 8'(ns);
  endtask

  task automatic run_row(input vec_t r, input int id);
    int n;
    int armc;
    int d0;
    ev_t e;
    e.peak = r.peak; e.idx = r.idx; e.seq = 8'd0;
    sb.push_back(e);
    set_cfg(r.h, r.w, r.g, 1);
    d0 = n_done;
    start = 1'b1; s_beat = r.gap ? 1'b0 : 1'b1; det_in = 1'b0;
    step();
    start = 1'b0;
    set_cfg(1, 1, 1, 7);  // must not affect the running search
    chk($sformatf("row%0d_busy_rise", id), {31'd0, busy}, 32'd1);
    n = 1; armc = 0;
    while (!done && n < 400) begin
      if (arm) armc++;
      det_in = (r.det != 0) && arm && (armc == r.det);
      s_beat = r.gap ? n[0] : 1'b1;
      step();
      n++;
    end
    det_in = 1'b0; s_beat = 1'b0;
    chk($sformatf("row%0d_done_seen", id), {31'd0, done}, 32'd1);
    chk($sformatf("row%0d_busy_fall", id), {31'd0, busy}, 32'd0);
    chk($sformatf("row%0d_arm_cycles", id), armc, r.armc);
    chk($sformatf("row%0d_done_count", id), n_done - d0, 1);
    chk($sformatf("row%0d_sb_drained", id), sb.size(), 0);
    chk($sformatf("row%0d_pk_seq_end", id), {24'd0, pk_seq}, 32'd1);
    if (r.peak) last_idx = r.idx;
    chk($sformatf("row%0d_pk_index_hold", id), pk_index, last_idx);
    sb.delete();
    step();
  endtask

  initial begin
    int busy_low;
    int d0;
    ev_t e;
    reset = 1'b1; clear = 1'b0; start = 1'b0; stop = 1'b0; s_beat = 1'b0; det_in = 1'b0;
    set_cfg(0, 0, 0, 0);

    // h, w, g, gap, det, peak, idx, armc
    vt[0] = '{4, 10, 3, 1'b0, 6, 1'b1, 10, 6};   // basic hit
    vt[1] = '{2,  5, 1, 1'b0, 0, 1'b0,  0, 6};   // timeout
    vt[2] = '{1,  3, 0, 1'b0, 4, 1'b1,  5, 4};   // det on expiry cycle
    vt[3] = '{0,  0, 2, 1'b0, 0, 1'b0,  0, 1};   // zero window expires
    vt[4] = '{0,  0, 0, 1'b0, 1, 1'b1,  1, 1};   // zero window, det wins
    vt[5] = '{3,  4, 2, 1'b1, 3, 1'b1,  4, 3};   // gapped stream
    vt[6] = '{0,  2, 1, 1'b1, 0, 1'b0,  0, 5};   // gapped timeout

    step(); step();
    reset = 1'b0;
    chk("rst_arm", {31'd0, arm}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pk_valid", {31'd0, pk_valid}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pk_index", pk_index, 32'd0);
    chk("rst_pk_seq", {24'd0, pk_seq}, 32'd0);

    // stop in IDLE does nothing
    stop = 1'b1; step(); stop = 1'b0; step();
    chk("idle_stop_busy", {31'd0, busy}, 32'd0);
    chk("idle_stop_done", n_done, 0);

    // clear during the second window's SEARCH
    set_cfg(0, 1, 0, 3);
    e.peak = 1'b0; e.idx = 0; e.seq = 8'd0;
    sb.push_back(e);
    s_beat = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (sb.size() == 0 && arm) break;
    end
    chk("clr_pre_arm", {31'd0, arm}, 32'd1);
    chk("clr_pre_seq", {24'd0, pk_seq}, 32'd1);
    clear = 1'b1; step(); clear = 1'b0;
    chk("clr_arm", {31'd0, arm}, 32'd0);
    chk("clr_busy", {31'd0, busy}, 32'd0);
    chk("clr_pk_seq", {24'd0, pk_seq}, 32'd0);
    chk("clr_done", {31'd0, done}, 32'd0);
    step(); step(); step();
    chk("clr_no_done", n_done, 0);
    s_beat = 1'b0;
    sb.delete();

    for (int i = 0; i < 7; i++) run_row(vt[i], i);

    // start+stop together in IDLE: start accepted; later stop beats det_in
    set_cfg(0, 10, 0, 1);
    s_beat = 1'b1;
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    chk("ss_busy", {31'd0, busy}, 32'd1);
    for (int k = 0; k < 20 && !arm; k++) step();
    step();
    chk("ss_arm_before_stop", {31'd0, arm}, 32'd1);
    d0 = n_done;
    det_in = 1'b1; stop = 1'b1; step(); det_in = 1'b0; stop = 1'b0;
    chk("stop_done", {31'd0, done}, 32'd1);
    chk("stop_no_pk_valid", {31'd0, pk_valid}, 32'd0);
    chk("stop_busy", {31'd0, busy}, 32'd0);
    chk("stop_arm", {31'd0, arm}, 32'd0);
    step();
    chk("stop_done_once", n_done - d0, 1);
    chk("stop_pk_index_hold", pk_index, last_idx);

    // continuous mode: 300 windows with pk_seq wrapping
    set_cfg(0, 2, 0, 0);
    for (int i = 0; i < 300; i++) begin
      e.peak = 1'b0; e.idx = 0; e.seq = 8'(i % 256);
      sb.push_back(e);
    end
    busy_low = 0;
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 2000 && sb.size() > 0; k++) begin
      start = (k == 100);  // ignored while busy
      step();
      if (!busy) busy_low++;
    end
    start = 1'b0;
    chk("cont_drained", sb.size(), 0);
    chk("cont_busy_low_cycles", busy_low, 0);
    chk("cont_no_done_yet", {31'd0, done}, 32'd0);
    sb.delete();
    d0 = n_done;
    stop = 1'b1; step(); stop = 1'b0;
    chk("cont_done", {31'd0, done}, 32'd1);
    chk("cont_busy_fall", {31'd0, busy}, 32'd0);
    chk("cont_pk_seq_wrap", {24'd0, pk_seq}, 32'd43);
    step(); step();
    chk("cont_done_once", n_done - d0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/peak_search_sched.md
# peak_search_sched

Sequencer for the streaming peak detector. It arms the detector for repeated, bounded search windows, separated by a holdoff and a guard interval, all measured in accepted sample beats. It timestamps each reported peak against a run-relative sample counter and flags windows that expire without a detection. It sits beside the detector on the same sample stream, taking settings from the radio's register block and reporting results to the status/readback path.

## Interface
- CNT_WIDTH, 16: width of the holdoff, window and guard configuration values and their counters.
- TS_WIDTH, 32: width of the sample timestamp counter.
- clk  in  1  clock for the whole block.
- reset  in  1  synchronous, active-high.
- clear  in  1  synchronous, active-high soft clear; identical effect to reset.
- start  in  1  one-cycle request to begin a run; honoured only in IDLE.
- stop  in  1  one-cycle abort request; honoured in any non-IDLE state.
- cfg_holdoff  in  CNT_WIDTH  beats between the start of a run and the first window.
- cfg_window  in  CNT_WIDTH  maximum beats per search window.
- cfg_guard  in  CNT_WIDTH  beats after each window before the next window opens.
- cfg_nsearch  in  8  windows per run; 0 = continuous until stop.
- s_beat  in  1  sample accepted on the monitored stream (tvalid & tready).
- det_in  in  1  peak strobe returned by the detector.
- arm  out  1  arm/trigger level to the detector.
- busy  out  1  high whenever state != IDLE.
- pk_valid  out  1  one-cycle pulse: a peak was reported.
- pk_index  out  TS_WIDTH  timestamp of the reported peak; holds its value until the next pk_valid.
- pk_seq  out  8  index of the window that produced the result (starts at 0).
- timeout  out  1  one-cycle pulse: window expired without a detection.
- done  out  1  one-cycle pulse: run ended (completed or stopped).

## Operation
- States: IDLE, HOLDOFF, SEARCH, GUARD.
- Configuration is latched on an accepted start. Changes to the cfg inputs during a run have no effect.
- Phase counter:
  - Cleared on entry to HOLDOFF, SEARCH and GUARD.
  - Increments on each s_beat.
  - Saturates at its all-ones value.
- Timestamp counter:
  - Cleared on an accepted start.
  - Increments on each s_beat while busy.
  - Wraps modulo 2^TS_WIDTH.
- IDLE: on start, go to HOLDOFF. pk_seq <= 0.
- HOLDOFF: when phase count == cfg_holdoff, go to SEARCH. With cfg_holdoff = 0, the state is left after one cycle.
- SEARCH:
  - When det_in = 1: pk_valid pulse, pk_index <= timestamp counter value in that cycle, go to GUARD.
  - Else, when phase count == cfg_window: timeout pulse, go to GUARD.
  - When det_in and window expiry occur in the same cycle, the detection wins and no timeout is issued.
  - With cfg_window = 0, the window times out after one cycle unless det_in is high in that cycle.
- GUARD:
  - When phase count == cfg_guard, increment pk_seq.
  - If cfg_nsearch != 0 and the incremented pk_seq == cfg_nsearch: done pulse, go to IDLE.
  - Otherwise go to SEARCH.
  - With cfg_nsearch = 0, pk_seq wraps at 255 and the run continues.
- det_in is ignored outside SEARCH.
- stop:
  - From any non-IDLE state: go to IDLE next cycle, done pulse, arm low, no pk_valid/timeout from that cycle.
  - stop takes priority over a same-cycle det_in.
  - In IDLE, stop is ignored.
- start while busy is ignored. start and stop together in IDLE: the start is accepted.

## Timing
- All outputs are registered.
- Reset values: arm = 0, busy = 0, pk_valid = 0, timeout = 0, done = 0, pk_index = 0, pk_seq = 0. State = IDLE and both counters = 0.
- Phase and state timing:
  - arm = 1 exactly in the cycles where the registered state is SEARCH. It rises the cycle after the HOLDOFF/GUARD exit condition.
  - busy rises the cycle after start and falls in the same cycle that done is high.
  - pk_valid/timeout are high in the first cycle of GUARD. arm is already 0 in that cycle.
  - done is high in the first IDLE cycle.
- Latency from det_in sampled high to pk_valid: 1 cycle.
- Each phase costs exactly one extra cycle after its last counted beat, because the compare is on the registered count.
- reset/clear mid-run:
  - Returns to IDLE immediately, with no done pulse.
  - arm is low the next cycle.

## Test plan
- Basic hit: holdoff = 4, window = 10, guard = 3, nsearch = 1, s_beat continuous, det_in high at the 6th SEARCH cycle -> pk_valid once, pk_index = 10, pk_seq = 0, done the cycle after GUARD ends, timeout never asserted.
- Timeout: window = 5, det_in held low -> timeout once after 5 beats in SEARCH, arm high for exactly 6 cycles, no pk_valid.
- Gapped stream: s_beat on alternate cycles, holdoff = 3 -> SEARCH entered after 3 beats (6 clock cycles + 1). pk_index counts beats, not cycles.
- Collision and priority: det_in on the expiry cycle -> pk_valid, no timeout. det_in with stop in the same cycle -> done, no pk_valid.
- Continuous mode: nsearch = 0, window = 2, guard = 0, 300 windows -> pk_seq wraps 255 -> 0, busy stays high until stop, then done pulses once.
- Reset mid-SEARCH with arm = 1 -> arm, busy and pk_seq = 0 the next cycle, no done. A later start runs normally with timestamps from 0.
